// File: rtl/clock_pkg.sv
// clock_pkg: shared types and BCD helpers for the clock/timer blocks.
//   bcd2_t      two-digit BCD value {tens, units}
//   cd_state_t  countdown timer FSM states
//   bcd2_dec    decrement a 00..59 BCD value, wrapping 00 -> 59 with a borrow out
//   bcd2_valid  true when tens <= 5 and units <= 9
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_RUN,
        CD_PAUSE,
        CD_DONE
    } cd_state_t;

    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_UNIT = 4'd9;

    // Single-digit decrement as a lookup so no binary carry ever crosses
    // a digit boundary; caller handles 0 separately.
    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        logic [3:0] r;
        case (d)
            4'd1:    r = 4'd0;
            4'd2:    r = 4'd1;
            4'd3:    r = 4'd2;
            4'd4:    r = 4'd3;
            4'd5:    r = 4'd4;
            4'd6:    r = 4'd5;
            4'd7:    r = 4'd6;
            4'd8:    r = 4'd7;
            4'd9:    r = 4'd8;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic bcd2_t bcd2_dec(input bcd2_t in, output logic borrow);
        logic [3:0] tens;
        logic [3:0] units;
        tens   = in[7:4];
        units  = in[3:0];
        borrow = 1'b0;
        if (units != 4'd0) begin
            units = digit_dec(units);
        end else begin
            units = BCD_MAX_UNIT;
            if (tens != 4'd0) begin
                tens = digit_dec(tens);
            end else begin
                tens   = BCD_MAX_TENS;
                borrow = 1'b1;
            end
        end
        return {tens, units};
    endfunction

    function automatic logic bcd2_valid(input bcd2_t in);
        return (in[7:4] <= BCD_MAX_TENS) && (in[3:0] <= BCD_MAX_UNIT);
    endfunction

endpackage

// File: rtl/cd_tick_gen.sv
// cd_tick_gen: 1 s prescaler for the countdown timer.
//   clk, rst  system clock, synchronous active-high reset
//   en        count enable (low holds the current count)
//   clr       clear count to 0 (wins over en)
//   tick      combinational: en and count at TICK_DIV-1; count wraps on that edge
module cd_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loads an MM:SS BCD value and counts it down to 00:00.
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   i_start               start/pause button level (rising edge used)
//   i_load                load strobe; i_load_min / i_load_sec are the BCD preset
//   sec, min              BCD time remaining
//   running               high while counting
//   tick_flag             one-cycle pulse per applied 1 s decrement
//   o_done                one-cycle pulse on reaching 00:00
//   o_alarm               level while expired (DONE)
//   o_load_err            one-cycle pulse when a load carries an invalid BCD digit
module countdown_timer
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       i_start,
    input  logic       i_load,
    input  logic [7:0] i_load_min,
    input  logic [7:0] i_load_sec,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       running,
    output logic       tick_flag,
    output logic       o_done,
    output logic       o_alarm,
    output logic       o_load_err
);

    cd_state_t state;
    logic      start_q;
    logic      start_edge;
    logic      load_req;
    logic      load_ok;
    logic      tick;
    logic      tick_en;
    logic      tick_clr;
    bcd2_t     sec_dec;
    bcd2_t     min_dec;
    bcd2_t     min_nx;
    logic      sec_borrow;
    logic      min_borrow;
    logic      hits_zero;

    always_comb begin
        start_edge = i_start & ~start_q;
        // Loads are only looked at outside RUN; in RUN they vanish silently.
        load_req   = i_load && (state != CD_RUN);
        load_ok    = load_req && bcd2_valid(i_load_min) && bcd2_valid(i_load_sec);
        // A start edge on the tick cycle pauses and freezes the prescaler at
        // its last count, so the first RUN cycle after resume ticks.
        tick_en    = (state == CD_RUN) && !start_edge;
        // Prescaler is zeroed whenever idle (covers IDLE -> RUN) and on a
        // successful load out of PAUSE/DONE.
        tick_clr   = (state == CD_IDLE) || load_ok;

        sec_dec    = bcd2_dec(sec, sec_borrow);
        min_dec    = bcd2_dec(min, min_borrow);
        min_nx     = sec_borrow ? min_dec : min;
        // Borrowing out of 00:00 cannot happen from RUN, but if it ever did
        // the timer saturates at zero rather than wrapping to 59:59.
        hits_zero  = ((sec_dec == 8'h00) && (min_nx == 8'h00)) || (sec_borrow && min_borrow);
    end

    cd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= CD_IDLE;
            sec        <= 8'h00;
            min        <= 8'h00;
            start_q    <= 1'b0;
            running    <= 1'b0;
            tick_flag  <= 1'b0;
            o_done     <= 1'b0;
            o_alarm    <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            start_q    <= i_start;
            tick_flag  <= 1'b0;
            o_done     <= 1'b0;
            o_load_err <= 1'b0;

            if (load_req) begin
                // Load has priority; any simultaneous start edge is dropped.
                if (load_ok) begin
                    sec     <= i_load_sec;
                    min     <= i_load_min;
                    state   <= CD_IDLE;
                    running <= 1'b0;
                    o_alarm <= 1'b0;
                end else begin
                    o_load_err <= 1'b1;
                end
            end else begin
                case (state)
                    CD_IDLE: begin
                        if (start_edge && ((sec != 8'h00) || (min != 8'h00))) begin
                            state   <= CD_RUN;
                            running <= 1'b1;
                        end
                    end
                    CD_RUN: begin
                        if (start_edge) begin
                            state   <= CD_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            tick_flag <= 1'b1;
                            if (hits_zero) begin
                                sec     <= 8'h00;
                                min     <= 8'h00;
                                state   <= CD_DONE;
                                running <= 1'b0;
                                o_done  <= 1'b1;
                                o_alarm <= 1'b1;
                            end else begin
                                sec <= sec_dec;
                                min <= min_nx;
                            end
                        end
                    end
                    CD_PAUSE: begin
                        if (start_edge) begin
                            state   <= CD_RUN;
                            running <= 1'b1;
                        end
                    end
                    CD_DONE: begin
                        if (start_edge) begin
                            state   <= CD_IDLE;
                            o_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= CD_IDLE;
                        running <= 1'b0;
                        o_alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with TICK_DIV=4.
// Flags are compared packed as {running, tick_flag, o_done, o_alarm, o_load_err}.
module tb_countdown_timer;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       i_start;
    logic       i_load;
    logic [7:0] i_load_min;
    logic [7:0] i_load_sec;
    logic [7:0] sec;
    logic [7:0] min;
    logic       running;
    logic       tick_flag;
    logic       o_done;
    logic       o_alarm;
    logic       o_load_err;

    int tests = 0;
    int fails = 0;

    countdown_timer #(
        .TICK_DIV (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .i_start    (i_start),
        .i_load     (i_load),
        .i_load_min (i_load_min),
        .i_load_sec (i_load_sec),
        .sec        (sec),
        .min        (min),
        .running    (running),
        .tick_flag  (tick_flag),
        .o_done     (o_done),
        .o_alarm    (o_alarm),
        .o_load_err (o_load_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Compare time value and flags at the current sample point.
    task automatic chk(input string tag, input logic [7:0] emin, input logic [7:0] esec,
                       input logic [4:0] eflags);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {min, sec, running, tick_flag, o_done, o_alarm, o_load_err};
        exp = {emin, esec, eflags};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed min=%h sec=%h flags=%b, expected min=%h sec=%h flags=%b",
                   tag, obs[20:13], obs[12:5], obs[4:0], emin, esec, eflags);
        end
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        i_load     = 1'b1;
        i_load_min = m;
        i_load_sec = s;
        cyc(1);
        i_load     = 1'b0;
    endtask

    task automatic press;
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
    endtask

    initial begin
        sys_rst    = 1'b1;
        i_start    = 1'b0;
        i_load     = 1'b0;
        i_load_min = 8'h00;
        i_load_sec = 8'h00;
        cyc(2);
        sys_rst = 1'b0;
        chk("reset", 8'h00, 8'h00, 5'b00000);

        // 1. 01:00 counts to 00:59 then 00:58
        load(8'h01, 8'h00);
        chk("load_0100", 8'h01, 8'h00, 5'b00000);
        press;
        chk("run_entry", 8'h01, 8'h00, 5'b10000);
        cyc(3);
        chk("pre_tick", 8'h01, 8'h00, 5'b10000);
        cyc(1);
        chk("tick_0059", 8'h00, 8'h59, 5'b11000);
        cyc(1);
        chk("tick_flag_clr", 8'h00, 8'h59, 5'b10000);
        cyc(3);
        chk("tick_0058", 8'h00, 8'h58, 5'b11000);

        // 2. expiry from 00:02
        press;
        chk("pause", 8'h00, 8'h58, 5'b00000);
        load(8'h00, 8'h02);
        chk("load_0002", 8'h00, 8'h02, 5'b00000);
        press;
        cyc(4);
        chk("tick_0001", 8'h00, 8'h01, 5'b11000);
        cyc(4);
        chk("expire", 8'h00, 8'h00, 5'b01110);
        cyc(1);
        chk("alarm_hold", 8'h00, 8'h00, 5'b00010);
        press;
        chk("done_to_idle", 8'h00, 8'h00, 5'b00000);

        // 3. pause at prescaler=2 keeps the fraction
        load(8'h00, 8'h10);
        press;
        cyc(2);
        press;
        chk("pause_p2", 8'h00, 8'h10, 5'b00000);
        cyc(20);
        chk("pause_hold", 8'h00, 8'h10, 5'b00000);
        press;
        chk("resume", 8'h00, 8'h10, 5'b10000);
        cyc(1);
        chk("resume_pre", 8'h00, 8'h10, 5'b10000);
        cyc(1);
        chk("resume_tick", 8'h00, 8'h09, 5'b11000);

        // tick and start edge together: pause wins, tick comes right after resume
        cyc(3);
        press;
        chk("tick_vs_pause", 8'h00, 8'h09, 5'b00000);
        cyc(1);
        press;
        chk("resume_at_last", 8'h00, 8'h09, 5'b10000);
        cyc(1);
        chk("first_run_tick", 8'h00, 8'h08, 5'b11000);

        // 4. load in RUN ignored, no error
        load(8'h00, 8'h05);
        chk("load_in_run", 8'h00, 8'h08, 5'b10000);
        press;
        chk("pause2", 8'h00, 8'h08, 5'b00000);

        // 5. load + start in PAUSE: load wins, stays IDLE
        i_start = 1'b1;
        load(8'h05, 8'h00);
        i_start = 1'b0;
        chk("load_vs_start", 8'h05, 8'h00, 5'b00000);
        cyc(2);
        chk("load_vs_start_idle", 8'h05, 8'h00, 5'b00000);

        // bad loads in IDLE
        load(8'h00, 8'h6A);
        chk("bad_unit", 8'h05, 8'h00, 5'b00001);
        cyc(1);
        chk("err_clr", 8'h05, 8'h00, 5'b00000);
        load(8'h60, 8'h00);
        chk("bad_min_tens", 8'h05, 8'h00, 5'b00001);
        load(8'h00, 8'h75);
        chk("bad_sec_tens", 8'h05, 8'h00, 5'b00001);

        // borrow through minute tens: 10:00 -> 09:59
        load(8'h10, 8'h00);
        press;
        cyc(4);
        chk("borrow_min_tens", 8'h09, 8'h59, 5'b11000);

        // 6. reset mid-RUN at 03:27
        press;
        load(8'h03, 8'h28);
        press;
        cyc(4);
        chk("at_0327", 8'h03, 8'h27, 5'b11000);
        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        chk("reset_mid_run", 8'h00, 8'h00, 5'b00000);
        press;
        chk("start_at_zero", 8'h00, 8'h00, 5'b00000);
        cyc(5);
        chk("zero_stays_idle", 8'h00, 8'h00, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
